// File: rtl/ps2_output.sv
// ps2_output: host-to-device PS2 transmitter (inhibit, RTS, 11-bit shift-out, ACK check)
module ps2_output #(
  parameter int INHIBIT_CYCLES = 200,
  parameter int RTS_CYCLES     = 10,
  parameter int TIMEOUT_CYCLES = 40000
) (
  input  logic       clk_slow,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       tx_done,
  output logic       tx_error
);
  localparam int PW = $clog2((INHIBIT_CYCLES > RTS_CYCLES ? INHIBIT_CYCLES : RTS_CYCLES) + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic [2:0] {IDLE, INHIBIT, RTS, SHIFT, ACK_WAIT, ACK_REL} state_t;
  state_t        state_q;
  logic [PW-1:0] cnt_q;
  logic [TW-1:0] to_q;
  logic [3:0]    bit_q;
  logic [9:0]    frame_q;
  logic [1:0]    clk_sync_q, data_sync_q;
  logic          clk_prev_q, clk_oe_q, data_oe_q, done_q, error_q;
  logic          fall, to_hit;
  assign fall        = clk_prev_q & ~clk_sync_q[1];
  assign to_hit      = to_q == TW'(TIMEOUT_CYCLES - 1);
  assign tx_ready    = state_q == IDLE && !done_q && !error_q;
  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;
  assign tx_done     = done_q;
  assign tx_error    = error_q;
  always_ff @(posedge clk_slow or negedge rst)
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      to_q        <= '0;
      bit_q       <= '0;
      frame_q     <= '0;
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
      clk_prev_q  <= 1'b1;
      clk_oe_q    <= 1'b0;
      data_oe_q   <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      clk_sync_q  <= {clk_sync_q[0], ps2_clk_in};
      data_sync_q <= {data_sync_q[0], ps2_data_in};
      clk_prev_q  <= clk_sync_q[1];
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      case (state_q)
        IDLE:
          if (tx_valid && tx_ready) begin
            frame_q  <= {1'b1, ~^tx_data, tx_data};
            cnt_q    <= '0;
            clk_oe_q <= 1'b1;
            state_q  <= INHIBIT;
          end
        INHIBIT:
          if (cnt_q == PW'(INHIBIT_CYCLES - 1)) begin
            cnt_q     <= '0;
            data_oe_q <= 1'b1;
            state_q   <= RTS;
          end else cnt_q <= cnt_q + 1'b1;
        RTS:
          if (cnt_q == PW'(RTS_CYCLES - 1)) begin
            clk_oe_q <= 1'b0;
            bit_q    <= '0;
            to_q     <= '0;
            state_q  <= SHIFT;
          end else cnt_q <= cnt_q + 1'b1;
        default: begin
          to_q <= to_q + 1'b1;
          // timeout wins over any edge landing in the same cycle
          if (to_hit) begin
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
            error_q   <= 1'b1;
            state_q   <= IDLE;
          end else if (state_q == SHIFT) begin
            if (fall) begin
              data_oe_q <= ~frame_q[bit_q];
              bit_q     <= bit_q + 1'b1;
              if (bit_q == 4'd9) state_q <= ACK_WAIT;
            end
          end else if (state_q == ACK_WAIT) begin
            if (fall) begin
              error_q <= data_sync_q[1];
              state_q <= data_sync_q[1] ? IDLE : ACK_REL;
            end
          end else if (clk_sync_q[1] && data_sync_q[1]) begin
            done_q  <= 1'b1;
            state_q <= IDLE;
          end
        end
      endcase
    end
endmodule

// File: tb/tb_ps2_output.sv
// tb_ps2_output: directed bench with a behavioural PS2 device model
module tb_ps2_output;
  localparam int TO = 2000;
  localparam int H  = 40;
  typedef struct {
    logic [7:0] d;
    logic       par;
    logic       ack;
    int         exp_done;
    int         exp_err;
  } vec_t;
  logic       clk_slow = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, ps2_clk_oe, ps2_data_oe, tx_done, tx_error;
  logic       dev_clk_low = 1'b0, dev_data_low = 1'b0;
  logic       clk_line, data_line;
  int         checks = 0, errors = 0, done_cnt = 0, err_cnt = 0;
  assign clk_line  = ~(ps2_clk_oe | dev_clk_low);
  assign data_line = ~(ps2_data_oe | dev_data_low);
  always #500 clk_slow = ~clk_slow;
  ps2_output #(.INHIBIT_CYCLES(200), .RTS_CYCLES(10), .TIMEOUT_CYCLES(TO)) dut (
    .clk_slow(clk_slow), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .ps2_clk_in(clk_line), .ps2_data_in(data_line), .ps2_clk_oe(ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe), .tx_done(tx_done), .tx_error(tx_error)
  );
  always @(negedge clk_slow) begin
    done_cnt += int'(tx_done);
    err_cnt  += int'(tx_error);
    if (tx_done && tx_error) begin
      errors++;
      $display("FAIL done_and_error: both pulses high at %0t", $time);
    end
  end
  initial begin
    #80_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask
  task automatic send(input logic [7:0] d);
    @(negedge clk_slow);
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge clk_slow);
    tx_valid = 1'b0;
  endtask
  task automatic wait_release();
    int n = 0;
    while (ps2_clk_oe && n < 1000) begin
      @(negedge clk_slow);
      n++;
    end
  endtask
  // Device side: measures inhibit/RTS, samples start bit, then 10 clocks sampling on rise, then ACK clock.
  task automatic device(input logic ack, output logic [10:0] bits, output int inh, output int rts);
    int n = 0;
    bits = '0;
    inh  = 0;
    rts  = 0;
    while (!ps2_clk_oe && n < 50) begin
      @(negedge clk_slow);
      n++;
    end
    while (ps2_clk_oe && !ps2_data_oe && inh < 1000) begin
      inh++;
      @(negedge clk_slow);
    end
    while (ps2_clk_oe && ps2_data_oe && rts < 1000) begin
      rts++;
      @(negedge clk_slow);
    end
    repeat (10) @(negedge clk_slow);
    bits[0] = data_line;
    for (int k = 1; k <= 10; k++) begin
      dev_clk_low = 1'b1;
      repeat (H) @(negedge clk_slow);
      dev_clk_low = 1'b0;
      bits[k] = data_line;
      repeat (H) @(negedge clk_slow);
    end
    dev_data_low = ack;
    repeat (H / 2) @(negedge clk_slow);
    dev_clk_low = 1'b1;
    repeat (H) @(negedge clk_slow);
    dev_clk_low = 1'b0;
    repeat (H) @(negedge clk_slow);
    dev_data_low = 1'b0;
  endtask
  initial begin
    vec_t       v[5];
    logic [10:0] bits;
    int         inh, rts, d0, e0, n;
    v[0] = '{8'hED, 1'b1, 1'b1, 1, 0};
    v[1] = '{8'h01, 1'b0, 1'b1, 1, 0};
    v[2] = '{8'hFF, 1'b1, 1'b1, 1, 0};
    v[3] = '{8'h00, 1'b1, 1'b0, 0, 1};
    v[4] = '{8'hA5, 1'b1, 1'b1, 1, 0};
    repeat (3) @(negedge clk_slow);
    check("reset_ready", int'(tx_ready), 1);
    check("reset_clk_oe", int'(ps2_clk_oe), 0);
    check("reset_data_oe", int'(ps2_data_oe), 0);
    check("reset_done", int'(tx_done), 0);
    check("reset_error", int'(tx_error), 0);
    rst = 1'b1;
    repeat (3) @(negedge clk_slow);
    for (int i = 0; i < 5; i++) begin
      d0 = done_cnt;
      e0 = err_cnt;
      send(v[i].d);
      device(v[i].ack, bits, inh, rts);
      repeat (20) @(negedge clk_slow);
      check($sformatf("v%0d_bits", i), int'(bits), int'({1'b1, v[i].par, v[i].d, 1'b0}));
      check($sformatf("v%0d_odd_parity", i), $countones(bits[9:1]) % 2, 1);
      check($sformatf("v%0d_inhibit", i), inh, 200);
      check($sformatf("v%0d_rts", i), rts, 10);
      check($sformatf("v%0d_done", i), done_cnt - d0, v[i].exp_done);
      check($sformatf("v%0d_error", i), err_cnt - e0, v[i].exp_err);
      check($sformatf("v%0d_released", i), int'(ps2_clk_oe | ps2_data_oe), 0);
      if (i == 0) check("ed_literal", int'(bits), 'h7DA);
    end
    d0 = done_cnt;
    e0 = err_cnt;
    send(8'h12);
    wait_release();
    n = 0;
    while (!tx_error && n < TO + 100) begin
      @(negedge clk_slow);
      n++;
    end
    check("timeout_cycles", n, TO);
    check("timeout_clk_oe", int'(ps2_clk_oe), 0);
    check("timeout_data_oe", int'(ps2_data_oe), 0);
    repeat (5) @(negedge clk_slow);
    check("timeout_error", err_cnt - e0, 1);
    check("timeout_no_done", done_cnt - d0, 0);
    d0 = done_cnt;
    e0 = err_cnt;
    send(8'h00);
    wait_release();
    repeat (10) @(negedge clk_slow);
    for (int k = 1; k <= 4; k++) begin
      dev_clk_low = 1'b1;
      repeat (H) @(negedge clk_slow);
      if (k < 4) begin
        dev_clk_low = 1'b0;
        repeat (H) @(negedge clk_slow);
      end
    end
    check("midframe_data_oe", int'(ps2_data_oe), 1);
    check("midframe_not_ready", int'(tx_ready), 0);
    #100 rst = 1'b0;
    #1;
    check("async_rst_clk_oe", int'(ps2_clk_oe), 0);
    check("async_rst_data_oe", int'(ps2_data_oe), 0);
    check("async_rst_ready", int'(tx_ready), 1);
    repeat (3) @(negedge clk_slow);
    dev_clk_low = 1'b0;
    rst = 1'b1;
    repeat (5) @(negedge clk_slow);
    check("rst_no_pulses", (done_cnt - d0) + (err_cnt - e0), 0);
    send(8'hF4);
    device(1'b1, bits, inh, rts);
    repeat (20) @(negedge clk_slow);
    check("retry_bits", int'(bits), int'({1'b1, 1'b0, 8'hF4, 1'b0}));
    check("retry_done", done_cnt - d0, 1);
    d0 = done_cnt;
    @(negedge clk_slow);
    tx_data  = 8'h55;
    tx_valid = 1'b1;
    @(negedge clk_slow);
    tx_data = 8'hAA;
    device(1'b1, bits, inh, rts);
    check("held_first_bits", int'(bits), int'({1'b1, 1'b1, 8'h55, 1'b0}));
    n = 0;
    while (!tx_ready && n < 100) begin
      @(negedge clk_slow);
      n++;
    end
    check("held_first_done", done_cnt - d0, 1);
    @(negedge clk_slow);
    tx_valid = 1'b0;
    device(1'b1, bits, inh, rts);
    repeat (20) @(negedge clk_slow);
    check("held_second_bits", int'(bits), int'({1'b1, 1'b1, 8'hAA, 1'b0}));
    check("held_second_inhibit", inh, 200);
    check("held_second_done", done_cnt - d0, 2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
